// File: rtl/onehot16_index_fifo.sv
// onehot16_index_fifo
// Checks a 16-bit one-hot word from the decode stage and converts a legal word
// back to its 4-bit index. The index is buffered in a small first-word-fall-through
// FIFO. Illegal words (zero bits set, or more than one) are dropped and counted
// in a sticky flag and a saturating counter.
//
// Handshake: a transfer happens on a rising clk edge only when valid and ready
// are both high. On the input side that is in_valid && in_ready, and in_ready
// depends only on the fill level, never on out_ready. On the output side it is
// out_valid && out_ready. Every output comes from registers, so there is no
// combinational path from input to output.
module onehot16_index_fifo #(
    parameter int DEPTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [15:0]              in_onehot,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [3:0]               out_idx,
    input  logic                     out_ready,
    input  logic                     err_clr,
    output logic                     err_flag,
    output logic [ERR_CNT_W-1:0]     err_count,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [3:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [4:0]    hot_cnt;
    logic [3:0]    hot_idx;
    logic          legal;
    logic          accept;
    logic          push;
    logic          pop;

    // Count the set bits and remember the position of the set bit. The position
    // is only meaningful when exactly one bit is set.
    always_comb begin
        hot_cnt = '0;
        hot_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (in_onehot[i]) begin
                hot_cnt = hot_cnt + 5'd1;
                hot_idx = 4'(i);
            end
        end
    end

    assign legal     = (hot_cnt == 5'd1);
    assign in_ready  = (level != LW'(DEPTH));
    assign out_valid = (level != '0);
    assign out_idx   = mem[rd_ptr];
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign pop       = out_valid && out_ready;

    // FIFO storage, pointers and fill level. The pointers wrap naturally
    // because DEPTH is a power of two. The storage is cleared on reset so that
    // out_idx reads 0 afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= hot_idx;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

    // Error tracking. A clear takes priority over an illegal word accepted in
    // the same cycle, so that word is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag  <= 1'b0;
            err_count <= '0;
        end else if (err_clr) begin
            err_flag  <= 1'b0;
            err_count <= '0;
        end else if (accept && !legal) begin
            err_flag <= 1'b1;
            if (!(&err_count)) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_onehot16_index_fifo.sv
// Testbench for onehot16_index_fifo. It uses directed scenarios plus a random
// phase, and compares the DUT against a queue-based reference model.
module tb_onehot16_index_fifo;

    localparam int DEPTH     = 4;
    localparam int ERR_CNT_W = 8;
    localparam int ERR_MAX   = (1 << ERR_CNT_W) - 1;

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic [15:0]            in_onehot;
    logic                   in_ready;
    logic                   out_valid;
    logic [3:0]             out_idx;
    logic                   out_ready;
    logic                   err_clr;
    logic                   err_flag;
    logic [ERR_CNT_W-1:0]   err_count;
    logic [$clog2(DEPTH):0] level;

    onehot16_index_fifo #(.DEPTH(DEPTH), .ERR_CNT_W(ERR_CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_onehot (in_onehot),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_ready (out_ready),
        .err_clr   (err_clr),
        .err_flag  (err_flag),
        .err_count (err_count),
        .level     (level)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic [3:0] exp_q[$];
    int         m_cnt;
    logic       m_flag;
    int         checks;
    int         failures;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // For a one-hot word 2**k, the index of the set bit is log2 of the word.
    function automatic logic [3:0] idx_of(input logic [15:0] w);
        return 4'($clog2(w));
    endfunction

    function automatic logic [15:0] rand_illegal();
        logic [15:0] w;
        w = 16'($urandom);
        if ($countones(w) == 1) w = ($urandom_range(0, 1) == 0) ? 16'h0000 : (w | 16'h0081) & ~(w & 16'h0000);
        if ($countones(w) == 1) w = 16'h0000;
        return w;
    endfunction

    task automatic compare_all();
        check("level", 32'(level), 32'(exp_q.size()));
        check("in_ready", 32'(in_ready), 32'(exp_q.size() != DEPTH));
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) check("out_idx", 32'(out_idx), 32'(exp_q[0]));
        check("err_flag", 32'(err_flag), 32'(m_flag));
        check("err_count", 32'(err_count), 32'(m_cnt));
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_cnt  = 0;
        m_flag = 1'b0;
    endtask

    // driver: apply inputs for one clock, update the model at the edge, and
    // check at the following falling edge
    task automatic step(input logic v, input logic [15:0] w, input logic ordy,
                        input logic clr, output logic acc);
        logic pop;
        in_valid  = v;
        in_onehot = w;
        out_ready = ordy;
        err_clr   = clr;
        acc = v && (exp_q.size() != DEPTH);
        pop = (exp_q.size() != 0) && ordy;
        @(posedge clk);
        if (pop) void'(exp_q.pop_front());
        if (acc) begin
            if ($countones(w) == 1) exp_q.push_back(idx_of(w));
            else if (!clr) begin
                m_flag = 1'b1;
                if (m_cnt < ERR_MAX) m_cnt++;
            end
        end
        if (clr) begin
            m_flag = 1'b0;
            m_cnt  = 0;
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        step(1'b0, 16'h0000, ordy, 1'b0, acc);
    endtask

    // Holds the word until the model accepts it, within a cycle budget.
    task automatic send(input logic [15:0] w, input logic ordy, input logic clr);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            step(1'b1, w, ordy, clr, acc);
            n++;
        end
        check("send_accept_timeout", 32'(acc), 32'd1);
    endtask

    initial begin
        logic acc;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_onehot = '0;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_out_idx", 32'(out_idx), 32'd0);
        compare_all();

        // 1: all sixteen legal words back-to-back with the consumer ready
        for (int i = 0; i < 16; i++) send(16'(1 << i), 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        check("t1_err_count", 32'(err_count), 32'd0);

        // 2: fill while stalled, hold off a fifth word, then drain
        send(16'h0004, 1'b0, 1'b0);
        send(16'h0100, 1'b0, 1'b0);
        send(16'h8000, 1'b0, 1'b0);
        send(16'h0002, 1'b0, 1'b0);
        check("t2_full_level", 32'(level), 32'd4);
        check("t2_full_in_ready", 32'(in_ready), 32'd0);
        step(1'b1, 16'h0010, 1'b0, 1'b0, acc);
        step(1'b1, 16'h0010, 1'b0, 1'b0, acc);
        send(16'h0010, 1'b1, 1'b0);
        repeat (6) idle(1'b1);

        // 3: illegal words, then a clear together with another illegal word
        send(16'h0000, 1'b1, 1'b0);
        send(16'h0101, 1'b1, 1'b0);
        check("t3_count2", 32'(err_count), 32'd2);
        check("t3_no_out", 32'(out_valid), 32'd0);
        send(16'h00f0, 1'b1, 1'b1);
        check("t3_cleared", 32'(err_count), 32'd0);

        // 4: saturate the error counter
        for (int i = 0; i < 300; i++) send(rand_illegal(), 1'b1, 1'b0);
        check("t4_saturated", 32'(err_count), 32'(ERR_MAX));
        check("t4_level", 32'(level), 32'd0);

        // 5: hold level at 2 while pushing and popping every cycle across the wrap
        send(16'h0001, 1'b0, 1'b1);
        send(16'h0002, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) send(16'(1 << ((i + 2) % 16)), 1'b1, 1'b0);
        check("t5_level", 32'(level), 32'd2);
        repeat (3) idle(1'b1);

        // 6: asynchronous reset in mid-operation
        for (int i = 0; i < 5; i++) send(16'h0003, 1'b0, 1'b0);
        send(16'h0008, 1'b0, 1'b0);
        send(16'h0020, 1'b0, 1'b0);
        send(16'h0400, 1'b0, 1'b0);
        check("t6_pre_level", 32'(level), 32'd3);
        check("t6_pre_count", 32'(err_count), 32'd5);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("t6_rst_out_valid", 32'(out_valid), 32'd0);
        check("t6_rst_level", 32'(level), 32'd0);
        check("t6_rst_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(16'h0040, 1'b0, 1'b0);
        check("t6_out_idx", 32'(out_idx), 32'd6);
        idle(1'b1);

        // random phase
        for (int i = 0; i < 2000; i++) begin
            logic [15:0] w;
            if ($urandom_range(0, 9) < 7) w = 16'(1 << $urandom_range(0, 15));
            else w = rand_illegal();
            step($urandom_range(0, 3) != 0, w, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 19) == 0, acc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
